// File: rtl/gradient_pkg.sv
// Shared types, widths and round-robin helper for the gradient arbiter and its datapath.
package gradient_pkg;

    localparam int GRAD_W = 8;
    localparam int SUM_W  = 17;

    typedef logic [GRAD_W-1:0] grad_t;

    localparam grad_t G_MAX = 8'd255;

    // Wraps an index that has stepped at most one lap past the lane count.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/total_gradient.sv
// Combinational gradient magnitude: g = min(255, floor(sqrt(gx^2 + gy^2))).
module total_gradient
    import gradient_pkg::*;
(
    input  grad_t gx,
    input  grad_t gy,
    output grad_t g
);

    localparam int ROOT_W = 9;
    localparam int SQ_W   = 2 * ROOT_W;

    logic [SUM_W-1:0]  sum;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W-1:0] trial;

    assign sum = SUM_W'(gx) * SUM_W'(gx) + SUM_W'(gy) * SUM_W'(gy);

    // Bit-serial square root: keep each root bit whose square still fits under the sum.
    always_comb begin
        root  = '0;
        trial = '0;
        for (int b = ROOT_W - 1; b >= 0; b--) begin
            trial = root | (ROOT_W'(1) << b);
            if (SQ_W'(trial) * SQ_W'(trial) <= SQ_W'(sum)) begin
                root = trial;
            end
        end
        g = (root > {1'b0, G_MAX}) ? G_MAX : root[GRAD_W-1:0];
    end

endmodule

// File: rtl/gradient_arbiter.sv
// Round-robin arbiter sharing one total_gradient datapath across NUM_REQ lanes.
// Optional threshold output enabled by defining GRADIENT_ARB_THRESH_EN.
module gradient_arbiter
    import gradient_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*GRAD_W-1:0] req_gx,
    input  logic [NUM_REQ*GRAD_W-1:0] req_gy,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output grad_t                     resp_g,
    output logic [ID_W-1:0]           resp_id
`ifdef GRADIENT_ARB_THRESH_EN
    ,
    input  grad_t                     thresh,
    output logic                      resp_edge
`endif
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt;
    logic            any_valid;
    logic            accept;
    logic            transfer;
    grad_t           gx_sel;
    grad_t           gy_sel;
    grad_t           g_calc;

    // First valid lane at or after ptr, wrapping; any_valid guarantees gnt is a real requester.
    always_comb begin
        gnt = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[ID_W'(rr_wrap(int'(ptr) + k, NUM_REQ))]) begin
                gnt = ID_W'(rr_wrap(int'(ptr) + k, NUM_REQ));
            end
        end
    end

    assign any_valid = |req_valid;
    assign accept    = !resp_valid || resp_ready;
    assign transfer  = any_valid && accept && !clear;
    assign req_ready = transfer ? (NUM_REQ'(1) << gnt) : '0;

    assign gx_sel = req_gx[gnt*GRAD_W +: GRAD_W];
    assign gy_sel = req_gy[gnt*GRAD_W +: GRAD_W];

    total_gradient u_total_gradient (
        .gx (gx_sel),
        .gy (gy_sel),
        .g  (g_calc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            resp_valid <= 1'b0;
            resp_g     <= '0;
            resp_id    <= '0;
            ptr        <= '0;
        end else if (clear) begin
            resp_valid <= 1'b0;
            ptr        <= '0;
        end else if (transfer) begin
            resp_valid <= 1'b1;
            resp_g     <= g_calc;
            resp_id    <= gnt;
            ptr        <= ID_W'(rr_wrap(int'(gnt) + 1, NUM_REQ));
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef GRADIENT_ARB_THRESH_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            resp_edge <= 1'b0;
        end else if (!clear && transfer) begin
            resp_edge <= (g_calc >= thresh);
        end
    end
`endif

endmodule

// File: tb/tb_gradient_arbiter.sv
// Self-checking bench for gradient_arbiter: directed plan items plus randomized traffic vs a behavioural model.
module tb_gradient_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         clear;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*8-1:0] req_gx;
    logic [N*8-1:0] req_gy;
    logic         resp_valid;
    logic         resp_ready;
    logic [7:0]   resp_g;
    logic [1:0]   resp_id;
    logic [7:0]   gx [N];
    logic [7:0]   gy [N];
`ifdef GRADIENT_ARB_THRESH_EN
    logic [7:0]   thresh;
    logic         resp_edge;
`endif

    always #5 clk = ~clk;

    assign req_gx = {gx[3], gx[2], gx[1], gx[0]};
    assign req_gy = {gy[3], gy[2], gy[1], gy[0]};

    gradient_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_gx     (req_gx),
        .req_gy     (req_gy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_g     (resp_g),
        .resp_id    (resp_id)
`ifdef GRADIENT_ARB_THRESH_EN
        ,
        .thresh     (thresh),
        .resp_edge  (resp_edge)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: what the output slot and round-robin pointer must hold.
    int m_valid, m_g, m_id, m_ptr, m_edge;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int gref(input int a, input int b);
        int s, r;
        s = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return (r > 255) ? 255 : r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_g = 0; m_id = 0; m_ptr = 0; m_edge = 0;
    endtask

    // One clock: check DUT against model at negedge+1, advance model at posedge+1.
    task automatic step(output int granted);
        int gsel, xfer, th;
        int n_valid, n_g, n_id, n_ptr, n_edge;
        @(negedge clk);
        #1;
        gsel = -1;
        for (int k = 0; k < N; k++) begin
            if (gsel < 0 && req_valid[(m_ptr + k) % N]) gsel = (m_ptr + k) % N;
        end
        xfer = (gsel >= 0 && (m_valid == 0 || resp_ready) && !clear) ? 1 : 0;
        chk("req_ready", int'(req_ready), xfer ? (1 << gsel) : 0);
        chk("resp_valid", int'(resp_valid), m_valid);
        if (m_valid != 0) begin
            chk("resp_g", int'(resp_g), m_g);
            chk("resp_id", int'(resp_id), m_id);
`ifdef GRADIENT_ARB_THRESH_EN
            chk("resp_edge", int'(resp_edge), m_edge);
`endif
        end
`ifdef GRADIENT_ARB_THRESH_EN
        th = int'(thresh);
`else
        th = 0;
`endif
        n_valid = m_valid; n_g = m_g; n_id = m_id; n_ptr = m_ptr; n_edge = m_edge;
        if (clear) begin
            n_valid = 0; n_ptr = 0;
        end else if (xfer != 0) begin
            n_valid = 1;
            n_g     = gref(int'(gx[gsel]), int'(gy[gsel]));
            n_id    = gsel;
            n_ptr   = (gsel + 1) % N;
            n_edge  = (n_g >= th) ? 1 : 0;
        end else if (resp_ready) begin
            n_valid = 0;
        end
        granted = (xfer != 0) ? gsel : -1;
        @(posedge clk);
        #1;
        m_valid = n_valid; m_g = n_g; m_id = n_id; m_ptr = n_ptr; m_edge = n_edge;
    endtask

    initial begin
        int gr;
        int saved_g;
        int sx [6] = '{12, 24, 200, 213, 255, 0};
        int sy [6] = '{13, 106, 95, 156, 255, 0};
        int se [6] = '{17, 108, 221, 255, 255, 0};

        n_rst = 1'b0; clear = 1'b0; req_valid = '0; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin gx[i] = '0; gy[i] = '0; end
`ifdef GRADIENT_ARB_THRESH_EN
        thresh = 8'd100;
`endif
        model_reset();
        #12;
        chk("rst_valid", int'(resp_valid), 0);
        chk("rst_g", int'(resp_g), 0);
        chk("rst_id", int'(resp_id), 0);
        chk("rst_ready", int'(req_ready), 0);
`ifdef GRADIENT_ARB_THRESH_EN
        chk("rst_edge", int'(resp_edge), 0);
`endif
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;

        chk("model_pin_3_4", gref(3, 4), 5);
        chk("model_pin_213_156", gref(213, 156), 255);

        // Single lane 2: (3,4) -> 5 with id 2, ready for exactly one cycle.
        req_valid = 4'b0100; gx[2] = 8'd3; gy[2] = 8'd4;
        #1 chk("single_ready", int'(req_ready), 4);
        step(gr);
        req_valid = '0;
        #1;
        chk("single_ready_drop", int'(req_ready), 0);
        chk("single_valid", int'(resp_valid), 1);
        chk("single_g", int'(resp_g), 5);
        chk("single_id", int'(resp_id), 2);
`ifdef GRADIENT_ARB_THRESH_EN
        chk("single_edge", int'(resp_edge), 0);
`endif
        step(gr);

        // Arithmetic sweep through lane 1, back-to-back.
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b0010; gx[1] = 8'(sx[i]); gy[1] = 8'(sy[i]);
            step(gr);
            req_valid = '0;
            chk("sweep_g", int'(resp_g), se[i]);
            chk("sweep_id", int'(resp_id), 1);
`ifdef GRADIENT_ARB_THRESH_EN
            chk("sweep_edge", int'(resp_edge), (se[i] >= 100) ? 1 : 0);
`endif
        end

        // clear against a live grant: pointer sits at 2, lanes 0 and 3 request.
        req_valid = 4'b1001; gx[0] = 8'd6; gy[0] = 8'd8; gx[3] = 8'd5; gy[3] = 8'd12;
        clear = 1'b1;
        #1 chk("clear_ready", int'(req_ready), 0);
        step(gr);
        clear = 1'b0;
        #1;
        chk("clear_valid", int'(resp_valid), 0);
        chk("clear_restart", int'(req_ready), 1);
        step(gr);
        chk("clear_id", int'(resp_id), 0);
        chk("clear_g", int'(resp_g), 10);
        req_valid = '0;
        clear = 1'b1;
        step(gr);
        clear = 1'b0;

        // Fairness: all lanes valid, grants must rotate 0..3 twice with no bubbles.
        for (int i = 0; i < N; i++) begin gx[i] = 8'($urandom_range(0, 255)); gy[i] = 8'($urandom_range(0, 255)); end
        req_valid = 4'b1111;
        saved_g = 0;
        for (int k = 0; k < 8; k++) begin
            step(gr);
            chk("fair_gnt", gr, k % 4);
            chk("fair_valid", int'(resp_valid), 1);
            chk("fair_id", int'(resp_id), k % 4);
            if (gr >= 0) begin
                saved_g = gref(int'(gx[gr]), int'(gy[gr]));
                gx[gr] = 8'($urandom_range(0, 255)); gy[gr] = 8'($urandom_range(0, 255));
            end
        end

        // Backpressure: lanes 1 and 3 wait while the result for lane 3 is held.
        req_valid = 4'b1010; resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", int'(req_ready), 0);
            step(gr);
            chk("bp_valid", int'(resp_valid), 1);
            chk("bp_id", int'(resp_id), 3);
            chk("bp_g", int'(resp_g), saved_g);
        end
        resp_ready = 1'b1;
        step(gr);
        chk("bp_first", gr, 1);
        req_valid = 4'b1000;
        step(gr);
        chk("bp_second", gr, 3);
        chk("bp_second_id", int'(resp_id), 3);
        req_valid = '0;
        step(gr);

        // Randomized traffic; lanes hold valid and data until granted.
        for (int c = 0; c < 600; c++) begin
            step(gr);
            if (gr >= 0) req_valid[gr] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    gx[i] = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
                    gy[i] = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 24) == 0);
`ifdef GRADIENT_ARB_THRESH_EN
            if ($urandom_range(0, 15) == 0) thresh = 8'($urandom_range(0, 255));
`endif
        end
        clear = 1'b0; resp_ready = 1'b1; req_valid = '0;
        step(gr);

        // Asynchronous reset while a result is held.
        req_valid = 4'b0001; gx[0] = 8'd3; gy[0] = 8'd4;
        step(gr);
        req_valid = '0; resp_ready = 1'b0;
        chk("pre_rst_valid", int'(resp_valid), 1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_valid", int'(resp_valid), 0);
        chk("async_rst_g", int'(resp_g), 0);
        chk("async_rst_id", int'(resp_id), 0);
        chk("async_rst_ready", int'(req_ready), 0);
        model_reset();
        @(negedge clk); n_rst = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0100; gx[2] = 8'd8; gy[2] = 8'd15;
        step(gr);
        req_valid = '0;
        chk("post_rst_g", int'(resp_g), 17);
        step(gr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
